powerup_manager: RTL
====================

POWERUP_MANAGER -- requirements
Module: powerup_manager

Interface
REQ-001 SHALL take parameter FREEZE_TIME, default 5, freeze duration in seconds (1..15).
REQ-002 SHALL take parameter SHIELD_TIME, default 10, shield duration in seconds (1..15).
REQ-003 SHALL take parameter ROPE_TIME, default 10, double-rope duration in seconds (1..15).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port: col_present  input  1  one-cycle pulse from the presents controller: a present was collected.
REQ-008 SHALL have port: present_type  input  2  type of the collected present; valid only while col_present=1.
REQ-009 SHALL have port: secClk  input  1  one-cycle pulse, once per second.
REQ-010 SHALL have port: level_start  input  1  one-cycle pulse; cancels all effects.
REQ-011 SHALL have port: add_life  output  1  one-cycle pulse requesting one extra life.
REQ-012 SHALL have ports: freeze_active, shield_active, rope_double  output  1 each  effect enables for the ball, player and rope logic.
REQ-013 SHALL have ports: freeze_left, shield_left, rope_left  output  4 each  seconds remaining per effect.

Function
REQ-014 SHALL decode present_type as: 0=LIFE, 1=FREEZE, 2=SHIELD, 3=ROPE.
REQ-015 SHALL pulse add_life for exactly one cycle, in cycle N+1, when col_present=1 with LIFE in cycle N.
REQ-016 SHALL give each timed effect a two-state FSM, IDLE and ACTIVE, with a 4-bit down-counter.
REQ-017 SHALL, on a collect of the effect's type: IDLE->ACTIVE; counter loads its *_TIME; effect output is 1 from cycle N+1.
REQ-018 SHALL, on a collect while already ACTIVE, reload the counter to *_TIME (no accumulation) and stay ACTIVE.
REQ-019 SHALL, while ACTIVE, decrement the counter by 1 on each secClk pulse.
REQ-020 SHALL, on secClk with counter=1: counter->0 and state->IDLE; effect output is 0 from the next cycle.
REQ-021 SHALL give a collect priority over a simultaneous secClk: reload wins, no decrement that cycle.
REQ-022 SHALL give level_start priority over everything in the same cycle, including collect and secClk: all FSMs->IDLE, counters->0, no add_life pulse.
REQ-023 SHALL drive *_left equal to the counter, which is 0 in IDLE; counters never wrap below 0.
REQ-024 SHALL register all outputs, with no combinational path from any input to any output.
REQ-025 SHALL ignore present_type while col_present=0.
REQ-026 SHALL let the three timed effects run independently and concurrently.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, put all FSMs in IDLE, set all counters to 0, and drive add_life=0 and all effect outputs 0 next cycle.
REQ-028 SHALL abort any active effect when reset is asserted mid-effect; collects during reset are lost.
REQ-029 SHALL give reset priority over level_start and col_present.

Configuration
REQ-030 SHALL, with macro POWERUP_WARN_EN defined, add outputs freeze_warn, shield_warn, rope_warn (1 bit each, registered).
REQ-031 SHALL assert each *_warn while its effect is ACTIVE and its counter <= 2, so the HUD flashes the expiring effect.
REQ-032 SHALL, without POWERUP_WARN_EN, omit the *_warn ports and their logic entirely; all other behaviour is identical.

Structure
REQ-033 SHALL place in package powerup_pkg: the present-type enum (LIFE, FREEZE, SHIELD, ROPE), the effect-state enum (IDLE, ACTIVE), the 4-bit time typedef, and the default durations.
REQ-034 SHALL implement each timed effect as sub-module effect_timer, instantiated three times, with ports load, tick, clear, duration, active and left.

Verification
REQ-035 SHALL be verified with: col_present=1, type=0 in cycle 10 -> add_life=1 in cycle 11 only; no effect output changes.
REQ-036 SHALL be verified with: type=1 collect, then 5 secClk pulses -> freeze_left reads 5,4,3,2,1,0; freeze_active drops the cycle after the 5th pulse.
REQ-037 SHALL be verified with: SHIELD active with shield_left=3, then collect type=2 in the same cycle as secClk -> shield_left=10 next cycle.
REQ-038 SHALL be verified with: FREEZE, SHIELD and ROPE all active, then level_start pulse coinciding with col_present type=0 -> all outputs 0 next cycle, no add_life.
REQ-039 SHALL be verified with: ROPE active with rope_left=7, then reset high for 2 cycles -> rope_double=0 and rope_left=0; after release, the effect stays IDLE without a new collect.
REQ-040 SHALL be verified with, when POWERUP_WARN_EN is defined: shield counting down -> shield_warn=1 exactly while shield_left is in {2,1}.

Source files
------------

// File: rtl/powerup_pkg.sv
// Shared types and default durations for the power-up manager.
//
// Contents:
//   present_t      - decoded present type (LIFE, FREEZE, SHIELD, ROPE)
//   effect_state_t - per-effect FSM state (IDLE, ACTIVE)
//   time_t         - 4-bit seconds counter
//   DEF_*_TIME     - default effect durations in seconds
package powerup_pkg;

  typedef enum logic [1:0] {
    LIFE   = 2'd0,
    FREEZE = 2'd1,
    SHIELD = 2'd2,
    ROPE   = 2'd3
  } present_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } effect_state_t;

  typedef logic [3:0] time_t;

  localparam int DEF_FREEZE_TIME = 5;
  localparam int DEF_SHIELD_TIME = 10;
  localparam int DEF_ROPE_TIME   = 10;

endpackage

// File: rtl/effect_timer.sv
// One timed power-up effect: IDLE/ACTIVE FSM with a 4-bit seconds down-counter.
//
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   load       - (re)start the effect at `duration` seconds
//   tick       - once-per-second pulse; decrements while ACTIVE
//   clear      - cancel the effect (highest priority after reset)
//   duration   - reload value
//   active     - effect enabled (registered state)
//   left       - seconds remaining (0 while IDLE)
//   warn       - only with POWERUP_WARN_EN: ACTIVE with left <= 2
//
// Optional feature macro: POWERUP_WARN_EN.
module effect_timer
  import powerup_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  tick,
  input  logic  clear,
  input  time_t duration,
  output logic  active,
  output time_t left
`ifdef POWERUP_WARN_EN
  ,
  output logic  warn
`endif
);

  effect_state_t state_q, state_d;
  time_t         cnt_q, cnt_d;

  // Priority: clear > load > tick. A load that coincides with a tick
  // reloads without decrementing; reloading never accumulates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d = ACTIVE;
      cnt_d   = duration;
    end else if (tick && (state_q == ACTIVE)) begin
      // Expire on the tick that would take the counter to 0; the <= also
      // keeps the counter from wrapping should it ever read 0 while ACTIVE.
      if (cnt_q <= 4'd1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign active = (state_q == ACTIVE);
  assign left   = cnt_q;

`ifdef POWERUP_WARN_EN
  // Registered from next-state values so it lines up with left/active.
  logic warn_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= (state_d == ACTIVE) && (cnt_d <= 4'd2);
    end
  end
  assign warn = warn_q;
`endif

endmodule

// File: rtl/powerup_manager.sv
// Power-up manager: turns collected presents into an extra-life pulse and
// three independent timed effects (freeze, shield, double rope).
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   col_present       - one-cycle pulse: present collected
//   present_type      - type of collected present (valid with col_present)
//   secClk            - one-cycle pulse per second
//   level_start       - one-cycle pulse; cancels everything
//   add_life          - one-cycle pulse, cycle after a LIFE collect
//   freeze_active, shield_active, rope_double - effect enables
//   freeze_left, shield_left, rope_left       - seconds remaining
//   freeze_warn, shield_warn, rope_warn       - only with POWERUP_WARN_EN
//
// Handshake: col_present/secClk/level_start are single-cycle strobes with no
// back-pressure; present_type is only looked at while col_present is high.
// All outputs are registered.
//
// Optional feature macro: POWERUP_WARN_EN.
module powerup_manager
  import powerup_pkg::*;
#(
  parameter int FREEZE_TIME = DEF_FREEZE_TIME,
  parameter int SHIELD_TIME = DEF_SHIELD_TIME,
  parameter int ROPE_TIME   = DEF_ROPE_TIME
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       col_present,
  input  logic [1:0] present_type,
  input  logic       secClk,
  input  logic       level_start,
  output logic       add_life,
  output logic       freeze_active,
  output logic       shield_active,
  output logic       rope_double,
  output logic [3:0] freeze_left,
  output logic [3:0] shield_left,
  output logic [3:0] rope_left
`ifdef POWERUP_WARN_EN
  ,
  output logic       freeze_warn,
  output logic       shield_warn,
  output logic       rope_warn
`endif
);

  present_t ptype;
  logic     add_life_q;

  assign ptype = present_t'(present_type);

  always_ff @(posedge clk) begin
    if (reset) begin
      add_life_q <= 1'b0;
    end else begin
      add_life_q <= col_present && (ptype == LIFE) && !level_start;
    end
  end
  assign add_life = add_life_q;

  effect_timer u_freeze (
    .clk      (clk),
    .reset    (reset),
    .load     (col_present && (ptype == FREEZE)),
    .tick     (secClk),
    .clear    (level_start),
    .duration (time_t'(FREEZE_TIME)),
    .active   (freeze_active),
    .left     (freeze_left)
`ifdef POWERUP_WARN_EN
    ,
    .warn     (freeze_warn)
`endif
  );

  effect_timer u_shield (
    .clk      (clk),
    .reset    (reset),
    .load     (col_present && (ptype == SHIELD)),
    .tick     (secClk),
    .clear    (level_start),
    .duration (time_t'(SHIELD_TIME)),
    .active   (shield_active),
    .left     (shield_left)
`ifdef POWERUP_WARN_EN
    ,
    .warn     (shield_warn)
`endif
  );

  effect_timer u_rope (
    .clk      (clk),
    .reset    (reset),
    .load     (col_present && (ptype == ROPE)),
    .tick     (secClk),
    .clear    (level_start),
    .duration (time_t'(ROPE_TIME)),
    .active   (rope_double),
    .left     (rope_left)
`ifdef POWERUP_WARN_EN
    ,
    .warn     (rope_warn)
`endif
  );

endmodule
